// File: rtl/seq_mult_display_pkg.sv
// Shared types, sizing helpers and seven-segment table for the sequential
// multiplier display.
package seq_mult_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } mult_state_e;

    function automatic int unsigned num_digits(input int unsigned width);
        return (2 * width + 3) / 4;
    endfunction

    function automatic int unsigned scan_cnt_w(input int unsigned scan_count);
        return $clog2(scan_count + 1);
    endfunction

    function automatic int unsigned step_cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

    function automatic int unsigned digit_idx_w(input int unsigned digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

    // Active-high segments, bit order {g,f,e,d,c,b,a}; entry 15 first.
    localparam logic [15:0][6:0] SEG7_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] seg7_encode(input logic [3:0] nibble);
        return SEG7_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seq_mult_display_mult.sv
// Shift-add multiplier: IDLE -> CALC (WIDTH cycles) -> DONE (one cycle,
// valid pulse) -> IDLE.
module seq_shift_add_mult
    import seq_mult_display_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   factor_a_i,
    input  logic [WIDTH-1:0]   factor_b_i,
    output logic [2*WIDTH-1:0] product_o,
    output logic               busy_o,
    output logic               valid_o
);

    localparam int unsigned STEP_W = step_cnt_w(WIDTH);

    mult_state_e        state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [STEP_W-1:0]  step_q, step_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            step_q   <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            step_q   <= step_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        step_d   = step_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    mcand_d  = {{WIDTH{1'b0}}, factor_a_i};
                    mplier_d = factor_b_i;
                    acc_d    = '0;
                    step_d   = '0;
                    state_d  = ST_CALC;
                end
            end
            ST_CALC: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                step_d   = step_q + 1'b1;
                if (step_q == STEP_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign product_o = acc_q;
    assign busy_o    = (state_q == ST_CALC);
    assign valid_o   = (state_q == ST_DONE);

endmodule

// File: rtl/seq_mult_display.sv
// Multiplies two factors once per display frame and scans the committed
// product as hex digits on a shared seven-segment output.
module seq_mult_display
    import seq_mult_display_pkg::*;
#(
    parameter  int unsigned WIDTH      = 4,
    parameter  int unsigned SCAN_COUNT = 1250,
    localparam int unsigned NUM_DIGITS = num_digits(WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WIDTH-1:0]      i_factor_a,
    input  logic [WIDTH-1:0]      i_factor_b,
    input  logic                  i_hold,
    output logic [6:0]            o_segments,
    output logic [NUM_DIGITS-1:0] o_digit_sel,
    output logic                  o_busy,
    output logic                  o_valid
);

    localparam int unsigned CNT_W = scan_cnt_w(SCAN_COUNT);
    localparam int unsigned IDX_W = digit_idx_w(NUM_DIGITS);
    localparam int unsigned PAD_W = 4 * NUM_DIGITS;

    logic [CNT_W-1:0]      scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
    logic [2*WIDTH-1:0]    product_q, product_d;
    logic [3:0]            digit_q, digit_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;

    logic                  scan_wrap;
    logic                  last_digit;
    logic                  frame_end;
    logic                  mult_start;
    logic                  mult_valid;
    logic [2*WIDTH-1:0]    mult_acc;
    logic [PAD_W-1:0]      product_pad;

    seq_shift_add_mult #(
        .WIDTH (WIDTH)
    ) u_mult (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_i    (mult_start),
        .factor_a_i (i_factor_a),
        .factor_b_i (i_factor_b),
        .product_o  (mult_acc),
        .busy_o     (o_busy),
        .valid_o    (mult_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_cnt_q  <= '0;
            digit_idx_q <= '0;
            product_q   <= '0;
            digit_q     <= '0;
            sel_q       <= NUM_DIGITS'(1);
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            digit_idx_q <= digit_idx_d;
            product_q   <= product_d;
            digit_q     <= digit_d;
            sel_q       <= sel_d;
        end
    end

    assign product_pad = PAD_W'(product_q);

    always_comb begin
        scan_wrap   = (scan_cnt_q == CNT_W'(SCAN_COUNT));
        last_digit  = (digit_idx_q == IDX_W'(NUM_DIGITS - 1));
        frame_end   = scan_wrap && last_digit;
        mult_start  = frame_end && !i_hold;

        scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + 1'b1;
        digit_idx_d = digit_idx_q;
        if (scan_wrap) begin
            digit_idx_d = last_digit ? '0 : digit_idx_q + 1'b1;
        end

        product_d   = mult_valid ? mult_acc : product_q;
        // Digit and select are both registered from the same index so they
        // change on the same edge.
        digit_d     = product_pad[{digit_idx_q, 2'b00} +: 4];
        sel_d       = NUM_DIGITS'(1) << digit_idx_q;
    end

    assign o_segments  = seg7_encode(digit_q);
    assign o_digit_sel = sel_q;
    assign o_valid     = mult_valid;

endmodule
